// File: rtl/router.sv
// Four-port packet router. Each input keeps a one-packet buffer, and each
// output runs a round-robin-arbitrated transmit FSM. Packets are 4 bytes long.
module router #(
    parameter int NPORTS = 4
) (
    input  logic              clock,
    input  logic              reset_b,
    output logic [NPORTS-1:0] free_outbound,
    input  logic [NPORTS-1:0] put_outbound,
    input  logic [7:0]        payload_outbound [NPORTS],
    input  logic [NPORTS-1:0] free_inbound,
    output logic [NPORTS-1:0] put_inbound,
    output logic [7:0]        payload_inbound [NPORTS]
);
    typedef enum logic [1:0] {EMPTY, RECV, FULL} in_state_t;
    typedef enum logic {IDLE, SEND} out_state_t;

    in_state_t         in_state  [NPORTS];
    logic [2:0]        in_cnt    [NPORTS];
    logic [7:0]        pkt_buf   [NPORTS][4];
    out_state_t        out_state [NPORTS];
    logic [1:0]        out_cnt   [NPORTS];
    logic [1:0]        out_src   [NPORTS];
    logic [1:0]        rr_ptr    [NPORTS];
    logic [1:0]        grant_idx [NPORTS];
    logic [NPORTS-1:0] in_busy;
    logic [NPORTS-1:0] in_release;
    logic [NPORTS-1:0] grant_go;

    function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input int step);
        return ptr + 2'(step);
    endfunction

    // NOTE: state registers use non-blocking assignments so every port's next
    // state is computed from the same pre-edge values, independent of loop order.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NPORTS; i++) begin
                in_state[i] <= EMPTY;
                in_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                case (in_state[i])
                    EMPTY: if (put_outbound[i]) begin
                        in_state[i] <= RECV;
                        in_cnt[i]   <= 3'd1;
                    end
                    RECV: if (put_outbound[i]) begin
                        in_cnt[i] <= in_cnt[i] + 3'd1;
                        if (in_cnt[i] == 3'd3) in_state[i] <= FULL;
                    end else begin
                        in_state[i] <= EMPTY;
                        in_cnt[i]   <= '0;
                    end
                    FULL: if (in_release[i]) begin
                        in_state[i] <= EMPTY;
                        in_cnt[i]   <= '0;
                    end
                    default: begin
                        in_state[i] <= EMPTY;
                        in_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // NOTE: the packet buffer only holds data. Validity is tracked by in_state,
    // so the buffer needs no reset and maps onto plain storage.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (put_outbound[i] && (in_state[i] == EMPTY || in_state[i] == RECV))
                pkt_buf[i][in_cnt[i][1:0]] <= payload_outbound[i];
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            for (int k = 0; k < NPORTS; k++) begin
                out_state[k] <= IDLE;
                out_cnt[k]   <= '0;
                out_src[k]   <= '0;
                rr_ptr[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                if (out_state[k] == IDLE) begin
                    if (grant_go[k]) begin
                        out_state[k] <= SEND;
                        out_cnt[k]   <= 2'd1;
                        out_src[k]   <= grant_idx[k];
                    end
                end else if (out_cnt[k] == 2'd3) begin
                    out_state[k] <= IDLE;
                    out_cnt[k]   <= '0;
                    rr_ptr[k]    <= out_src[k] + 2'd1;
                end else begin
                    out_cnt[k] <= out_cnt[k] + 2'd1;
                end
            end
        end
    end

    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path holds an old value and no latch is inferred.
    always_comb begin
        in_busy    = '0;
        in_release = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (out_state[k] == SEND) begin
                in_busy[out_src[k]] = 1'b1;
                if (out_cnt[k] == 2'd3) in_release[out_src[k]] = 1'b1;
            end
        end
        for (int k = 0; k < NPORTS; k++) begin
            grant_go[k]  = 1'b0;
            grant_idx[k] = '0;
            for (int j = 0; j < NPORTS; j++) begin
                if (!grant_go[k] && in_state[rr_idx(rr_ptr[k], j)] == FULL &&
                    !in_busy[rr_idx(rr_ptr[k], j)] &&
                    pkt_buf[rr_idx(rr_ptr[k], j)][0][1:0] == 2'(k)) begin
                    grant_go[k]  = 1'b1;
                    grant_idx[k] = rr_idx(rr_ptr[k], j);
                end
            end
            if (out_state[k] != IDLE || !free_inbound[k]) grant_go[k] = 1'b0;
        end
    end

    // Byte0 leaves in the grant cycle itself, so the IDLE path is combinational.
    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            put_inbound[k]     = 1'b0;
            payload_inbound[k] = '0;
            if (out_state[k] == SEND) begin
                put_inbound[k]     = 1'b1;
                payload_inbound[k] = pkt_buf[out_src[k]][out_cnt[k]];
            end else if (grant_go[k]) begin
                put_inbound[k]     = 1'b1;
                payload_inbound[k] = pkt_buf[grant_idx[k]][0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPORTS; i++) free_outbound[i] = (in_state[i] == EMPTY);
    end
endmodule

// File: doc/router.md
ROUTER -- requirements
Module: router

Interface
REQ-001 The module SHALL have one parameter: NPORTS, default 4, number of node ports; only the value 4 is supported.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port reset_b, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port free_outbound[4], output, 1 bit each: tells node i that the router can accept a packet.
REQ-005 The module SHALL have port put_outbound[4], input, 1 bit each: node i is driving a byte.
REQ-006 The module SHALL have port payload_outbound[4], input, 8 bits each: byte from node i.
REQ-007 The module SHALL have port free_inbound[4], input, 1 bit each: node i can accept a packet.
REQ-008 The module SHALL have port put_inbound[4], output, 1 bit each: the router is driving a byte to node i.
REQ-009 The module SHALL have port payload_inbound[4], output, 8 bits each: byte to node i.

Function
REQ-010 Each packet SHALL be 4 bytes sent in this order: byte0 = {sourceID[3:0], destID[3:0]}, then data[23:16], data[15:8], data[7:0].
REQ-011 Each packet SHALL be routed to the output port selected by destID[1:0]; destID[3:2] SHALL be ignored.
REQ-012 Each input port SHALL have a one-packet buffer and a receive counter (0..4) and be in one of three states: EMPTY, RECV or FULL.
REQ-013 free_outbound[i] SHALL be 1 exactly when input i is EMPTY; it is a registered output with no combinational path from put_outbound.
REQ-014 In EMPTY, put_outbound[i]=1 SHALL capture byte0 and move the port to RECV with count 1; put while EMPTY is the only packet start.
REQ-015 In RECV, each cycle with put_outbound[i]=1 SHALL capture the next byte; capturing byte 3 SHALL move the port to FULL.
REQ-016 In RECV, a cycle with put_outbound[i]=0 SHALL abort the packet: the buffer is discarded and the port returns to EMPTY.
REQ-017 put_outbound[i] asserted while input i is FULL SHALL be ignored.
REQ-018 Each output port SHALL have a transmit FSM with states IDLE and SEND (byte counter 0..3) and a 2-bit round-robin pointer.
REQ-019 In IDLE, output k SHALL grant the first FULL input whose destination is k, searching from the pointer upward modulo 4, provided free_inbound[k]=1 and that input is not already granted to another output.
REQ-020 On the grant cycle, output k SHALL drive put_inbound[k]=1 with byte0 and move to SEND; bytes 1..3 SHALL follow on the next three consecutive cycles with put_inbound[k]=1, whatever free_inbound[k] does.
REQ-021 After byte 3 is driven, output k SHALL return to IDLE, the pointer SHALL become (granted input + 1) mod 4, and the granted input SHALL become EMPTY; free_outbound reasserts on the following cycle.
REQ-022 A new grant on output k SHALL be possible in the cycle right after byte 3, given free_inbound[k]=1.
REQ-023 A packet SHALL be granted no earlier than the cycle after its byte 3 is captured; minimum input-to-output latency is 1 cycle (byte0 out in the cycle following byte3 in).
REQ-024 A packet whose destination is its own port SHALL be legal and delivered normally.
REQ-025 While put_inbound[k]=0, payload_inbound[k] SHALL be 8'h00.
REQ-026 Byte order and content SHALL be preserved exactly; there is no reordering among packets from a single input.

Reset
REQ-027 When reset_b=0, all inputs SHALL go EMPTY, all outputs IDLE, round-robin pointers to 0, and counters to 0, asynchronously.
REQ-028 During reset, outputs SHALL be free_outbound=4'b1111, put_inbound=4'b0000 and payload_inbound=0.
REQ-029 Reset asserted mid-packet SHALL drop the partial packet with no resumption, and any in-flight output SHALL stop immediately.

Verification
REQ-030 Single packet test: node0 sends {0x0,0x2} then 0xAA, 0xBB, 0xCC in cycles 1-4 -> free_outbound[0]=0 from cycle 2; put_inbound[2]=1 in cycles 5-8 carrying 0x02, 0xAA, 0xBB, 0xCC; free_outbound[0]=1 at cycle 9.
REQ-031 Contention test: nodes 0, 1 and 3 each send to port 2 with the same timing -> deliveries arrive in order 0, 1, 3 back-to-back with no idle cycle; then a second identical round starting with the pointer at 0 -> order 0, 1, 3 again.
REQ-032 Parallel test: node0 sends to port 1 and node1 sends to port 0 simultaneously -> both deliveries happen in the same cycles.
REQ-033 Backpressure test: free_inbound[3]=0 while a packet for port 3 is FULL -> no put_inbound[3] and free_outbound stays 0; raising free_inbound[3] -> byte0 is delivered the same cycle.
REQ-034 Abort and reset test: node sends 2 bytes then drops put -> nothing is delivered and free_outbound reasserts; reset_b asserted during SEND byte 2 -> put_inbound drops immediately and all free_outbound=1.
